// File: rtl/fir_decim_fifo_if.sv
// Sample stream bundle between the FIR output stage and its neighbours:
// the upstream sample input and the downstream valid/ready drain port.
interface fir_decim_fifo_if #(
    parameter int L = 8
);
    logic [L-1:0] din;
    logic         din_valid;
    logic [L-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    // master: the environment (filter + consumer); slave: the decimating FIFO.
    modport master (output din, din_valid, dout_ready, input dout, dout_valid);
    modport slave  (input din, din_valid, dout_ready, output dout, dout_valid);
endinterface

// File: rtl/fir_decim_fifo.sv
// FIR output stage: keeps one sample in every DECIM valid samples and buffers
// them in a first-word-fall-through FIFO with fill level and sticky overflow.
module fir_decim_fifo #(
    parameter int L     = 8,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    fir_decim_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [PW-1:0] ph;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   level_q;
    logic [L-1:0]  mem [DEPTH];

    logic keep;
    logic pop;
    logic full;
    logic push;
    logic drop;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        keep = bus.din_valid && (ph == '0);
        pop  = bus.dout_valid && bus.dout_ready;
        full = (level_q == LVL_FULL);
        push = keep && (!full || pop);
        drop = keep && full && !pop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ph      <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            ovf     <= 1'b0;
        end else begin
            if (bus.din_valid)
                ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level_q <= level_q + 1'b1;
            else if (pop && !push)
                level_q <= level_q - 1'b1;
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by level/pointers, so
    // stale contents are never visible and the array maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= bus.din;
    end

    // NOTE: every combinational output gets a default first so no latch forms.
    always_comb begin
        bus.dout = '0;
        if (level_q != '0)
            bus.dout = mem[rd_ptr];
    end

    assign bus.dout_valid = (level_q != '0);
    assign level          = level_q;
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: expected drain order is queued with the
// stimulus and compared by an independent monitor on each accepted output.
module tb_fir_decim_fifo;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] level;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    fir_decim_fifo_if #(.L(8)) bus ();

    fir_decim_fifo #(.L(8), .DECIM(4), .DEPTH(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bus),
        .level  (level),
        .ovf    (ovf),
        .ovf_clr(ovf_clr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, return 1 time unit after it.
    task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic clr = 1'b0);
        bus.din_valid  = v;
        bus.din        = d;
        bus.dout_ready = rdy;
        ovf_clr        = clr;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: at the falling edge, whatever is presented with ready high
    // is popped at the next rising edge, so compare it with the queue head.
    always @(negedge CLK) begin
        if (bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got %0d expected no output", bus.dout);
            end else begin
                check("mon_dout", bus.dout, exp_q.pop_front());
            end
        end else if (!bus.dout_valid) begin
            check("mon_dout_zero_when_empty", bus.dout, 0);
        end
    end

    initial begin
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        #12;
        check("rst_level", level, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_ovf", ovf, 0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // Test 1: continuous valid stream, consumer always ready.
        exp_q.push_back(8'd0); exp_q.push_back(8'd4);
        exp_q.push_back(8'd8); exp_q.push_back(8'd12);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b1);
            check("t1_level_le1", (level <= 4'd1), 1);
            if (i % 4 == 0) begin
                check("t1_valid_next_cycle", bus.dout_valid, 1);
                check("t1_dout_next_cycle", bus.dout, i);
            end
        end
        check("t1_ovf", ovf, 0);
        cyc(1'b0, 8'd0, 1'b1);
        check("t1_level_end", level, 0);

        // Test 2: gaps in din_valid do not advance the phase.
        exp_q.push_back(8'd10); exp_q.push_back(8'd14);
        cyc(1'b1, 8'd10, 1'b1); cyc(1'b0, 8'hAA, 1'b1);
        cyc(1'b1, 8'd11, 1'b1); cyc(1'b0, 8'hAA, 1'b1);
        cyc(1'b1, 8'd12, 1'b1); cyc(1'b0, 8'hAA, 1'b1);
        cyc(1'b1, 8'd13, 1'b1); cyc(1'b0, 8'hAA, 1'b1);
        cyc(1'b1, 8'd14, 1'b1);
        // Three more valid samples realign the phase to 0 (none kept).
        cyc(1'b1, 8'd99, 1'b1); cyc(1'b1, 8'd99, 1'b1); cyc(1'b1, 8'd99, 1'b1);
        cyc(1'b0, 8'd0, 1'b1);
        check("t2_level_end", level, 0);

        // Test 3: consumer stalled, 40 samples -> 10 kept, 32 and 36 dropped.
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(4 * k));
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i == 28) begin
                check("t3_level_full", level, 8);
                check("t3_ovf_before_drop", ovf, 0);
            end
            if (i == 32) check("t3_ovf_after_drop", ovf, 1);
        end
        check("t3_level_sat", level, 8);

        // Test 5a: clear with no drop.
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check("t5_ovf_cleared", ovf, 0);

        // Test 4: full FIFO, keep and pop in the same cycle.
        exp_q.push_back(8'd200);
        cyc(1'b1, 8'd200, 1'b1);
        check("t4_level_stays_full", level, 8);
        check("t4_no_ovf", ovf, 0);

        // Test 5b: drop and clear in the same cycle -> set wins.
        cyc(1'b1, 8'd201, 1'b0); cyc(1'b1, 8'd201, 1'b0); cyc(1'b1, 8'd201, 1'b0);
        cyc(1'b1, 8'd202, 1'b0, 1'b1);
        check("t5_set_wins", ovf, 1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check("t5_ovf_cleared_again", ovf, 0);

        // Drain: 4,8,...,28 then 200; level counts down.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 8'd0, 1'b1);
            check("t3_drain_level", level, 7 - k);
        end
        check("t3_drained_valid", bus.dout_valid, 0);

        // Test 6: fill to 5 (phase is 1 here), then async reset mid-stream.
        cyc(1'b1, 8'hEE, 1'b0); cyc(1'b1, 8'hEE, 1'b0); cyc(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(100 + i), 1'b0);
        check("t6_level5", level, 5);
        RST = 1'b0;
        #2;
        check("t6_rst_valid", bus.dout_valid, 0);
        check("t6_rst_dout", bus.dout, 0);
        check("t6_rst_level", level, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_q.push_back(8'd77);
        cyc(1'b1, 8'd77, 1'b1);
        check("t6_first_kept_valid", bus.dout_valid, 1);
        check("t6_first_kept_dout", bus.dout, 77);
        cyc(1'b1, 8'd78, 1'b1);
        cyc(1'b0, 8'd0, 1'b1);
        cyc(1'b0, 8'd0, 1'b1);
        check("t6_level_end", level, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
Output stage directly downstream of the FIR filter. Takes the filter's L-bit output sample stream (one candidate sample per clock when valid), decimates by a fixed factor, and buffers the kept samples in a first-word-fall-through FIFO. The FIFO drains to the consumer over a valid/ready handshake. It also reports fill level and a sticky overflow flag, so back-pressure from the consumer never stalls the filter.

Parameters:
L, 8, sample width in bits; must match the FIR output width.
DECIM, 4, decimation factor (>=1); keep one sample in every DECIM valid samples.
DEPTH, 8, FIFO depth in samples; power of 2, >=2.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-low reset.
din  input  L  filtered sample (FIR Yn), unsigned.
din_valid  input  1  din is a new sample this cycle.
dout  output  L  head-of-FIFO sample; 0 whenever dout_valid=0.
dout_valid  output  1  FIFO not empty.
dout_ready  input  1  consumer accepts dout this cycle.
level  output  $clog2(DEPTH)+1  number of samples stored, 0..DEPTH.
ovf  output  1  sticky: a kept sample was dropped because FIFO was full.
ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (RST=0, async): phase counter=0, rd/wr pointers=0, level=0, dout_valid=0, dout=0, ovf=0. FIFO storage is not reset. Reset mid-operation discards all stored samples immediately.
- Phase counter ph, range 0..DECIM-1. Increments on each clock with din_valid=1 and wraps DECIM-1 -> 0. It holds when din_valid=0.
- Keep condition: din_valid=1 and ph==0. The first valid sample after reset is therefore kept, then every DECIM-th valid sample. With DECIM=1, every valid sample is kept.
- pop = dout_valid & dout_ready. push_req = keep condition.
- Push accepted if level<DEPTH, or if level==DEPTH and pop=1 in the same cycle (the slot freed by the pop is reused).
- If push_req=1, level==DEPTH and pop=0: the sample is dropped, ovf is set at that edge, and level, pointers and the phase counter continue normally.
- ovf_clr=1 clears ovf at the edge. If a drop happens in the same cycle as ovf_clr, set wins.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pop when empty: impossible, since dout_valid=0. dout_ready is ignored.
- Latency:
  - A sample accepted at edge k is visible on dout/dout_valid after edge k, i.e. one cycle later, when the FIFO was empty.
  - Otherwise it becomes the head after all older samples have been popped.
- dout = storage[rd_ptr] when level>0, else 0. dout is combinational from the registered pointer and storage; it holds stable while dout_valid=1 and dout_ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is a registered counter updated as +1 on push only, -1 on pop only, 0 change on both or neither.
- Samples are stored and emitted bit-exact; no arithmetic on data. Output order equals kept-sample input order.

Test Plan:
1. Reset, DECIM=4, din_valid=1 continuously with din=0,1,2,...,15 and dout_ready=1 -> dout emits 0,4,8,12, each one cycle after its input; level never exceeds 1; ovf=0.
2. din_valid toggling 1,0,1,0 with din=10,x,11,x,12,x,13,x,14 and dout_ready=1 -> only valid cycles advance the phase; outputs are 10 then 14.
3. dout_ready=0, feed 40 valid samples 0..39 (10 kept: 0,4,...,36) -> level saturates at 8; ovf=1 after the push of 32; then raise dout_ready -> dout emits 0,4,8,...,28 and level counts down to 0.
4. FIFO full (level=8): assert a keep-sample and pop in the same cycle -> no drop, ovf stays 0, level stays 8, and the new sample appears last in the drain order.
5. ovf=1, assert ovf_clr in a cycle with no drop -> ovf=0 next cycle. Repeat with a simultaneous drop -> ovf stays 1.
6. Mid-stream, with level=5, pull RST low for 1 cycle -> dout_valid=0, dout=0, level=0 immediately. After release, the first valid din is kept (phase restarts at 0).
